// File: rtl/hazard_detect_unit_if.sv
// hazard_detect_unit_if -- signal bundle between the pipeline datapath and
// the hazard detection unit.
//   master : pipeline side (drives operand/stage info, receives controls)
//   slave  : hazard unit side
interface hazard_detect_unit_if;

    // Operands of the instruction currently in ID
    logic [4:0]  ID_rs1;
    logic [4:0]  ID_rs2;
    logic        ID_uses_rs1;
    logic        ID_uses_rs2;

    // Instruction currently in EX
    logic [4:0]  ID_EX_rd;
    logic        ID_EX_mem_read;
    logic        branch_taken;

    // Instruction currently in MEM and the memory handshake
    logic        EX_MEM_mem_req;
    logic        mem_ready;

    // Pipeline controls
    logic        stall_IF;
    logic        stall_ID;
    logic        bubble_EX;
    logic        freeze;
    logic        flush_IF_ID;
    logic        flush_ID_EX;
    logic        mem_err;

    // Performance counters (constant zero unless HAZARD_PERF_EN is defined)
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;

    modport master (
        output ID_rs1, ID_rs2, ID_uses_rs1, ID_uses_rs2,
        output ID_EX_rd, ID_EX_mem_read, branch_taken,
        output EX_MEM_mem_req, mem_ready,
        input  stall_IF, stall_ID, bubble_EX, freeze,
        input  flush_IF_ID, flush_ID_EX, mem_err,
        input  stall_cycles, flush_count
    );

    modport slave (
        input  ID_rs1, ID_rs2, ID_uses_rs1, ID_uses_rs2,
        input  ID_EX_rd, ID_EX_mem_read, branch_taken,
        input  EX_MEM_mem_req, mem_ready,
        output stall_IF, stall_ID, bubble_EX, freeze,
        output flush_IF_ID, flush_ID_EX, mem_err,
        output stall_cycles, flush_count
    );

endinterface

// File: rtl/hazard_detect_unit.sv
// hazard_detect_unit -- pipeline hazard control for a 5-stage in-order core.
//
// Handles three hazard classes with priority
//   memory freeze  >  taken-branch flush  >  load-use stall.
// A MEM-stage access that is not ready freezes the back end (RUN -> MEM_WAIT)
// until mem_ready, or until MEM_TIMEOUT wait cycles have elapsed, at which
// point the access is abandoned and mem_err pulses for one cycle.
//
// Configuration macro:
//   HAZARD_PERF_EN  -- when defined, stall_cycles / flush_count count stall
//                      and flush cycles (wrapping). Otherwise both ports are
//                      tied to zero and no counter flops exist.
//
// MEM_TIMEOUT must lie in 1..255 (the wait counter is 8 bits wide).
module hazard_detect_unit #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rstn,
    hazard_detect_unit_if.slave  hz
);

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_wait_cnt;
    logic [8:0]  w_wait_next;
    logic        r_mem_err;

    logic        w_freeze;
    logic        w_wait_clr;
    logic        w_wait_inc;
    logic        w_timeout;

    logic        w_rs1_hit;
    logic        w_rs2_hit;
    logic        w_load_use;
    logic        w_lu_stall;
    logic        w_flush;

    logic        w_freeze_out;
    logic        w_stall_out;
    logic        w_bubble_out;
    logic        w_flush_out;

    // One extra bit so the timeout compare works for MEM_TIMEOUT = 255.
    assign w_wait_next = {1'b0, r_wait_cnt} + 9'd1;

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (!rstn) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and freeze generation for the memory-wait FSM.
    always_comb begin
        // NOTE: every output of this block gets a default before the case,
        // so no path can leave a value unassigned and infer a latch.
        w_state_next = r_state;
        w_freeze     = 1'b0;
        w_wait_clr   = 1'b0;
        w_wait_inc   = 1'b0;
        w_timeout    = 1'b0;

        case (r_state)
            ST_RUN: begin
                if (hz.EX_MEM_mem_req && !hz.mem_ready) begin
                    w_freeze     = 1'b1;
                    w_wait_clr   = 1'b1;
                    w_state_next = ST_MEM_WAIT;
                end
            end

            ST_MEM_WAIT: begin
                if (hz.mem_ready) begin
                    // Access completes this cycle: release the back end.
                    w_state_next = ST_RUN;
                end else begin
                    w_freeze   = 1'b1;
                    w_wait_inc = 1'b1;
                    if (w_wait_next == 9'(MEM_TIMEOUT)) begin
                        // Give up on the access; mem_err follows next cycle.
                        w_timeout    = 1'b1;
                        w_state_next = ST_RUN;
                    end
                end
            end
        endcase
    end

    // Wait counter: cleared on entry to MEM_WAIT, counts each MEM_WAIT cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wait_cnt <= '0;
        end else if (w_wait_clr) begin
            r_wait_cnt <= '0;
        end else if (w_wait_inc) begin
            r_wait_cnt <= w_wait_next[7:0];
        end
    end

    // Timeout pulse register: high for the single cycle after abandonment.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_mem_err <= 1'b0;
        end else begin
            r_mem_err <= w_timeout;
        end
    end

    // Hazard detection and priority resolution: freeze > flush > load-use.
    always_comb begin
        w_rs1_hit  = hz.ID_uses_rs1 && (hz.ID_rs1 == hz.ID_EX_rd);
        w_rs2_hit  = hz.ID_uses_rs2 && (hz.ID_rs2 == hz.ID_EX_rd);
        // x0 is hard-wired zero, so a load targeting it never creates a hazard.
        w_load_use = hz.ID_EX_mem_read && (hz.ID_EX_rd != 5'd0)
                     && (w_rs1_hit || w_rs2_hit);
        // A frozen branch keeps presenting branch_taken, so the flush simply
        // happens on the release cycle.
        w_flush    = hz.branch_taken && !w_freeze;
        // A taken branch squashes the dependent instruction anyway.
        w_lu_stall = w_load_use && (r_state == ST_RUN) && !w_freeze
                     && !hz.branch_taken;
    end

    // NOTE: the control outputs are combinational, so they are qualified
    // with rstn to stay low for the whole reset, not only after a clock edge.
    assign w_freeze_out = rstn && w_freeze;
    assign w_stall_out  = rstn && (w_freeze || w_lu_stall);
    assign w_bubble_out = rstn && w_lu_stall;
    assign w_flush_out  = rstn && w_flush;

    assign hz.freeze      = w_freeze_out;
    assign hz.stall_IF    = w_stall_out;
    assign hz.stall_ID    = w_stall_out;
    assign hz.bubble_EX   = w_bubble_out;
    assign hz.flush_IF_ID = w_flush_out;
    assign hz.flush_ID_EX = w_flush_out;
    assign hz.mem_err     = r_mem_err;

`ifdef HAZARD_PERF_EN
    logic [31:0] r_stall_cycles;
    logic [15:0] r_flush_count;

    // Performance counters; both wrap modulo their width.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (w_stall_out) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (w_flush_out) begin
                r_flush_count <= r_flush_count + 16'd1;
            end
        end
    end

    assign hz.stall_cycles = r_stall_cycles;
    assign hz.flush_count  = r_flush_count;
`else
    assign hz.stall_cycles = '0;
    assign hz.flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_detect_unit.sv
// tb_hazard_detect_unit -- directed scenarios with literal expectations,
// followed by randomized traffic compared every cycle against a behavioural
// model of the hazard rules.
module tb_hazard_detect_unit;

    localparam int TO = 4;

    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    hazard_detect_unit_if hz ();

    hazard_detect_unit #(.MEM_TIMEOUT(TO)) dut (
        .clk  (clk),
        .rstn (rstn),
        .hz   (hz)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    typedef struct packed {
        logic stall;
        logic bubble;
        logic freeze;
        logic flush;
    } exp_t;

    bit          m_waiting = 1'b0;  // a memory access is being waited on
    int          m_waited  = 0;     // wait cycles already spent
    bit          m_err     = 1'b0;  // mem_err expected this cycle
    logic [31:0] m_stalls  = '0;
    logic [15:0] m_flushes = '0;

    function automatic exp_t model_outputs();
        exp_t e;
        bit   lu;
        e = '0;
        if (!rstn) return e;
        if (m_waiting) e.freeze = !hz.mem_ready;
        else           e.freeze = hz.EX_MEM_mem_req && !hz.mem_ready;
        e.flush = hz.branch_taken && !e.freeze;
        lu = hz.ID_EX_mem_read && (hz.ID_EX_rd != 0) &&
             ((hz.ID_uses_rs1 && hz.ID_rs1 == hz.ID_EX_rd) ||
              (hz.ID_uses_rs2 && hz.ID_rs2 == hz.ID_EX_rd));
        e.bubble = lu && !m_waiting && !e.freeze && !hz.branch_taken;
        e.stall  = e.freeze || e.bubble;
        return e;
    endfunction

    function automatic logic [31:0] exp_stall_cnt();
`ifdef HAZARD_PERF_EN
        return m_stalls;
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [31:0] exp_flush_cnt();
`ifdef HAZARD_PERF_EN
        return {16'd0, m_flushes};
`else
        return 32'd0;
`endif
    endfunction

    // Model advance on each clock; reset clears it like the DUT.
    always @(posedge clk or negedge rstn) begin : model_upd
        exp_t e;
        e = model_outputs();
        if (!rstn) begin
            m_waiting <= 1'b0;
            m_waited  <= 0;
            m_err     <= 1'b0;
            m_stalls  <= '0;
            m_flushes <= '0;
        end else begin
            m_stalls  <= m_stalls + 32'(e.stall);
            m_flushes <= m_flushes + 16'(e.flush);
            m_err     <= m_waiting && !hz.mem_ready && (m_waited + 1 == TO);
            if (m_waiting) begin
                if (hz.mem_ready || (m_waited + 1 == TO)) m_waiting <= 1'b0;
                m_waited <= m_waited + 1;
            end else if (e.freeze) begin
                m_waiting <= 1'b1;
                m_waited  <= 0;
            end
        end
    end

    // Compare process: every falling edge, DUT against model.
    always @(negedge clk) begin : compare
        exp_t e;
        e = model_outputs();
        check("stall_IF",     32'(hz.stall_IF),    32'(e.stall));
        check("stall_ID",     32'(hz.stall_ID),    32'(e.stall));
        check("bubble_EX",    32'(hz.bubble_EX),   32'(e.bubble));
        check("freeze",       32'(hz.freeze),      32'(e.freeze));
        check("flush_IF_ID",  32'(hz.flush_IF_ID), 32'(e.flush));
        check("flush_ID_EX",  32'(hz.flush_ID_EX), 32'(e.flush));
        check("mem_err",      32'(hz.mem_err),     32'(m_err));
        check("stall_cycles", hz.stall_cycles,     exp_stall_cnt());
        check("flush_count",  32'(hz.flush_count), exp_flush_cnt());
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic set_idle();
        hz.ID_rs1         = 5'd0;
        hz.ID_rs2         = 5'd0;
        hz.ID_uses_rs1    = 1'b0;
        hz.ID_uses_rs2    = 1'b0;
        hz.ID_EX_rd       = 5'd0;
        hz.ID_EX_mem_read = 1'b0;
        hz.EX_MEM_mem_req = 1'b0;
        hz.mem_ready      = 1'b0;
        hz.branch_taken   = 1'b0;
    endtask

    task automatic set_load_use();
        hz.ID_EX_mem_read = 1'b1;
        hz.ID_EX_rd       = 5'd5;
        hz.ID_rs2         = 5'd5;
        hz.ID_uses_rs2    = 1'b1;
    endtask

    // Move to just after the next rising edge (inputs change here).
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Move to just after the falling edge (outputs are settled here).
    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic chk_ctl(input string tag, input logic stall, input logic bubble,
                           input logic freeze, input logic flush);
        check({tag, ".stall_IF"},    32'(hz.stall_IF),    32'(stall));
        check({tag, ".stall_ID"},    32'(hz.stall_ID),    32'(stall));
        check({tag, ".bubble_EX"},   32'(hz.bubble_EX),   32'(bubble));
        check({tag, ".freeze"},      32'(hz.freeze),      32'(freeze));
        check({tag, ".flush_IF_ID"}, 32'(hz.flush_IF_ID), 32'(flush));
        check({tag, ".flush_ID_EX"}, 32'(hz.flush_ID_EX), 32'(flush));
    endtask

    // ------------------------------------------------------------------
    // Directed scenarios, then random traffic
    // ------------------------------------------------------------------
    initial begin
        logic [31:0] exp_cnt;

        set_idle();
        rstn = 1'b1;
        #1 rstn = 1'b0;

        // Reset with every hazard input active: all controls low.
        set_load_use();
        hz.branch_taken   = 1'b1;
        hz.EX_MEM_mem_req = 1'b1;
        mid();
        chk_ctl("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset.mem_err",      32'(hz.mem_err), 32'd0);
        check("reset.stall_cycles", hz.stall_cycles, 32'd0);
        check("reset.flush_count",  32'(hz.flush_count), 32'd0);
        next();
        set_idle();
        rstn = 1'b1;

        // Load-use on rs2: one stall/bubble cycle, clear once the load leaves EX.
        set_load_use();
        mid();
        chk_ctl("load_use", 1'b1, 1'b1, 1'b0, 1'b0);
        next();
        set_idle();
        mid();
        chk_ctl("load_use_after", 1'b0, 1'b0, 1'b0, 1'b0);

        // Load to x0 read as rs1: never a hazard.
        next();
        hz.ID_EX_mem_read = 1'b1;
        hz.ID_EX_rd       = 5'd0;
        hz.ID_rs1         = 5'd0;
        hz.ID_uses_rs1    = 1'b1;
        mid();
        chk_ctl("x0_load", 1'b0, 1'b0, 1'b0, 1'b0);

        // Memory wait: three not-ready cycles frozen, released on the fourth.
        next();
        set_idle();
        hz.EX_MEM_mem_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mid();
            chk_ctl($sformatf("mem_wait%0d", i), 1'b1, 1'b0, 1'b1, 1'b0);
            next();
        end
        hz.mem_ready = 1'b1;
        mid();
        chk_ctl("mem_release", 1'b0, 1'b0, 1'b0, 1'b0);
        next();
        set_idle();
        mid();
        chk_ctl("mem_back_in_run", 1'b0, 1'b0, 1'b0, 1'b0);

        // Timeout: freeze through entry plus four wait cycles, then mem_err once.
        next();
        hz.EX_MEM_mem_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            mid();
            chk_ctl($sformatf("timeout_wait%0d", i), 1'b1, 1'b0, 1'b1, 1'b0);
            check($sformatf("timeout_wait%0d.mem_err", i), 32'(hz.mem_err), 32'd0);
            next();
        end
        hz.EX_MEM_mem_req = 1'b0;
        mid();
        check("timeout.mem_err", 32'(hz.mem_err), 32'd1);
        check("timeout.freeze",  32'(hz.freeze),  32'd0);
        next();
        mid();
        check("timeout_after.mem_err", 32'(hz.mem_err), 32'd0);

        // Branch held during a freeze: flush only on the release cycle.
        next();
        hz.EX_MEM_mem_req = 1'b1;
        hz.branch_taken   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mid();
            chk_ctl($sformatf("branch_frozen%0d", i), 1'b1, 1'b0, 1'b1, 1'b0);
            next();
        end
        hz.mem_ready = 1'b1;
        mid();
        chk_ctl("branch_release", 1'b0, 1'b0, 1'b0, 1'b1);
        next();
        set_idle();
        mid();
        chk_ctl("branch_after", 1'b0, 1'b0, 1'b0, 1'b0);

        // Branch together with load-use: flush wins, no stall or bubble.
        next();
        set_load_use();
        hz.branch_taken = 1'b1;
        mid();
        chk_ctl("branch_and_load_use", 1'b0, 1'b0, 1'b0, 1'b1);

        // Counters: fresh reset, ten load-use stalls, three flushes.
        next();
        set_idle();
        rstn = 1'b0;
        #2 rstn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            next();
            set_load_use();
            next();
            set_idle();
        end
        mid();
`ifdef HAZARD_PERF_EN
        exp_cnt = 32'd10;
`else
        exp_cnt = 32'd0;
`endif
        check("perf.stall_cycles", hz.stall_cycles, exp_cnt);
        for (int i = 0; i < 3; i++) begin
            next();
            hz.branch_taken = 1'b1;
            next();
            set_idle();
        end
        mid();
`ifdef HAZARD_PERF_EN
        exp_cnt = 32'd3;
`else
        exp_cnt = 32'd0;
`endif
        check("perf.flush_count", 32'(hz.flush_count), exp_cnt);

        // Reset pulse in the middle of MEM_WAIT: outputs drop immediately.
        next();
        hz.EX_MEM_mem_req = 1'b1;
        hz.branch_taken   = 1'b1;
        next();
        next();
        #2 rstn = 1'b0;
        #1;
        chk_ctl("reset_mid_wait", 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset_mid_wait.mem_err",      32'(hz.mem_err), 32'd0);
        check("reset_mid_wait.stall_cycles", hz.stall_cycles, 32'd0);
        check("reset_mid_wait.flush_count",  32'(hz.flush_count), 32'd0);
        next();
        set_idle();
        rstn = 1'b1;
        mid();
        chk_ctl("reset_mid_wait_after", 1'b0, 1'b0, 1'b0, 1'b0);

        // Random traffic against the model, small register space for many hits.
        for (int n = 0; n < 3000; n++) begin
            next();
            hz.ID_rs1         = 5'($urandom_range(0, 3));
            hz.ID_rs2         = 5'($urandom_range(0, 3));
            hz.ID_uses_rs1    = 1'($urandom_range(0, 1));
            hz.ID_uses_rs2    = 1'($urandom_range(0, 1));
            hz.ID_EX_rd       = 5'($urandom_range(0, 3));
            hz.ID_EX_mem_read = ($urandom_range(0, 1) == 0);
            hz.EX_MEM_mem_req = ($urandom_range(0, 3) == 0);
            hz.mem_ready      = ($urandom_range(0, 2) == 0);
            hz.branch_taken   = ($urandom_range(0, 6) == 0);
            if ($urandom_range(0, 499) == 0) begin
                #2 rstn = 1'b0;
                #1 rstn = 1'b1;
            end
        end
        next();
        set_idle();
        mid();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_detect_unit.md
HAZARD_DETECT_UNIT -- requirements
Module: hazard_detect_unit

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255, meaning the maximum number of MEM_WAIT cycles before abort.
REQ-002 SHALL have port clk  input  1  pipeline clock, rising edge.
REQ-003 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports ID_rs1, ID_rs2  input  5 each  source registers of the instruction in ID.
REQ-005 SHALL have ports ID_uses_rs1, ID_uses_rs2  input  1 each  the ID instruction reads rs1 / rs2.
REQ-006 SHALL have port ID_EX_rd  input  5  destination register of the instruction in EX.
REQ-007 SHALL have port ID_EX_mem_read  input  1  the EX instruction is a load.
REQ-008 SHALL have port EX_MEM_mem_req  input  1  the MEM-stage instruction issues a memory access.
REQ-009 SHALL have port mem_ready  input  1  memory access completes this cycle.
REQ-010 SHALL have port branch_taken  input  1  the EX instruction redirects the PC.
REQ-011 SHALL have ports stall_IF, stall_ID  output  1 each  hold the PC and the IF/ID register.
REQ-012 SHALL have port bubble_EX  output  1  load a NOP into ID/EX.
REQ-013 SHALL have port freeze  output  1  hold ID/EX and EX/MEM, and load a NOP into MEM/WB.
REQ-014 SHALL have ports flush_IF_ID, flush_ID_EX  output  1 each  squash younger instructions.
REQ-015 SHALL have port mem_err  output  1  one-cycle memory-timeout pulse.
REQ-016 SHALL have ports stall_cycles  output  32, and flush_count  output  16, as performance counters.

Function
REQ-017 SHALL implement a 2-state FSM: RUN and MEM_WAIT.
REQ-018 SHALL, in RUN with EX_MEM_mem_req=1 and mem_ready=0, assert freeze, stall_IF and stall_ID combinationally, and go to MEM_WAIT.
REQ-019 SHALL, in MEM_WAIT, keep freeze, stall_IF and stall_ID asserted until the cycle mem_ready=1.
- In that cycle it deasserts all three and returns to RUN.
REQ-020 SHALL keep an 8-bit wait counter.
- Cleared on entry to MEM_WAIT; increments each MEM_WAIT cycle.
- On reaching MEM_TIMEOUT: pulses mem_err for one cycle, deasserts freeze, returns to RUN.
REQ-021 SHALL detect load-use when all of these hold: RUN, no freeze, ID_EX_mem_read=1, ID_EX_rd!=0, and ID_EX_rd matches a used source (ID_rs1 with ID_uses_rs1, or ID_rs2 with ID_uses_rs2).
- Response: asserts stall_IF, stall_ID and bubble_EX for exactly one cycle.
REQ-022 SHALL, on branch_taken=1 with no freeze, assert flush_IF_ID and flush_ID_EX for one cycle.
REQ-023 SHALL apply priority freeze > branch flush > load-use stall.
- With branch and load-use in the same cycle: flush only, no stall or bubble.
REQ-024 SHALL suppress flush while freeze=1.
- The held EX instruction re-presents branch_taken, so the flush occurs on the release cycle.
REQ-025 SHALL treat x0 as never hazarding.
REQ-026 SHALL produce no stall or flush when no hazard condition holds.

Reset
REQ-027 SHALL, while rstn=0, force state=RUN, wait counter=0, mem_err=0 and both counters=0, asynchronously.
REQ-028 SHALL hold all stall, flush, bubble and freeze outputs at 0 during reset.
REQ-029 SHALL abandon MEM_WAIT immediately when reset is asserted mid-wait.

Configuration
REQ-030 SHALL implement the performance counters only when the macro HAZARD_PERF_EN is defined:
- stall_cycles increments on every cycle with stall_IF=1; flush_count increments on every flush cycle.
- Both wrap modulo 2^width.
REQ-031 SHALL, without HAZARD_PERF_EN, keep both ports present, drive them constant 0, and infer no counter flops.

Verification
REQ-032 SHALL cover load-use:
- Stimulus: ID_EX_mem_read=1, ID_EX_rd=5, ID_rs2=5, ID_uses_rs2=1.
- Response: stall_IF=stall_ID=bubble_EX=1 for 1 cycle, then 0 when the load leaves EX.
REQ-033 SHALL cover the x0 load:
- Stimulus: ID_EX_rd=0 with ID_rs1=0, ID_uses_rs1=1.
- Response: no stall.
REQ-034 SHALL cover memory wait:
- Stimulus: EX_MEM_mem_req=1; mem_ready low 3 cycles, then high.
- Response: freeze=1 for 3 cycles, 0 on the 4th; state back in RUN.
REQ-035 SHALL cover timeout:
- Stimulus: MEM_TIMEOUT=4, mem_ready never asserted.
- Response: mem_err=1 for exactly one cycle after 4 wait cycles; freeze then 0.
REQ-036 SHALL cover branch during freeze, then branch with load-use:
- Branch during freeze: no flush until release, then flush_IF_ID=flush_ID_EX=1 for 1 cycle.
- Branch together with load-use: flush=1, bubble_EX=0.
REQ-037 SHALL cover the counters:
- With HAZARD_PERF_EN and 10 stall cycles: stall_cycles=10.
- Without the macro: stall_cycles=0.
- rstn pulse mid-MEM_WAIT: all outputs 0 immediately.
